mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/risc_v_pkg.sv | 20 ++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/risc_v_pkg.sv
// Shared RISC-V core definitions: base opcodes and memory-arbiter state encoding.
package risc_v_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_BUSY = 2'd1,
        D_BUSY  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) single-port memory arbiter: data wins by default,
// fetch is forced through after STARVE_LIM consecutive data grants.
module mem_arbiter
    import risc_v_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_wr_en_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_ack_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_rd_en_o,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    // A zero limit still needs one counter bit; it simply never leaves zero.
    localparam int unsigned CNT_W = (STARVE_LIM == 0) ? 1 : $clog2(STARVE_LIM + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              starved;

    assign starved = if_req_i && (cnt_q == CNT_MAX);

    // Next-state, grant capture and same-cycle ack forwarding.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        if_ack_o   = 1'b0;
        d_ack_o    = 1'b0;
        if_rdata_o = '0;
        d_rdata_o  = '0;
        case (state_q)
            IDLE: begin
                if (!if_req_i) begin
                    cnt_d = '0;
                end
                if (d_req_i && !starved) begin
                    state_d = D_BUSY;
                    addr_d  = d_addr_i;
                    wdata_d = d_wdata_i;
                    wr_d    = d_wr_en_i;
                    // Not starved with fetch waiting implies cnt_q < CNT_MAX.
                    if (if_req_i) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (if_req_i) begin
                    state_d = IF_BUSY;
                    addr_d  = if_addr_i;
                    wdata_d = '0;
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            IF_BUSY: begin
                if (mem_ack_i) begin
                    if_ack_o   = 1'b1;
                    if_rdata_o = mem_rdata_i;
                    state_d    = IDLE;
                end
            end
            D_BUSY: begin
                if (mem_ack_i) begin
                    d_ack_o   = 1'b1;
                    d_rdata_o = mem_rdata_i;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
        end
    end

    // Strobes decode straight from registered state so they are glitch-free.
    assign mem_rd_en_o = (state_q == IF_BUSY) || ((state_q == D_BUSY) && !wr_q);
    assign mem_wr_en_o = (state_q == D_BUSY) && wr_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_mem_arbiter;
    import risc_v_pkg::*;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned LIM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, d_req, d_wr, mem_ack;
    logic [AW-1:0] if_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic          if_ack, d_ack, mem_rd, mem_wr;
    logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          if_ack0, d_ack0, mem_rd0, mem_wr0;
    logic [DW-1:0] if_rdata0, d_rdata0, mem_wdata0;
    logic [AW-1:0] mem_addr0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(LIM)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_wr_en_i(d_wr), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_ack_o(d_ack), .d_rdata_o(d_rdata),
        .mem_rd_en_o(mem_rd), .mem_wr_en_o(mem_wr), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIM(0)) dut0 (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack0), .if_rdata_o(if_rdata0),
        .d_req_i(d_req), .d_wr_en_i(d_wr), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_ack_o(d_ack0), .d_rdata_o(d_rdata0),
        .mem_rd_en_o(mem_rd0), .mem_wr_en_o(mem_wr0), .mem_addr_o(mem_addr0),
        .mem_wdata_o(mem_wdata0), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata)
    );

    task automatic clear_inputs();
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_wr = 1'b0;
        d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        #1;
        checks++;
        if ({mem_rd, mem_wr, if_ack, d_ack} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes got %b exp 0000", {mem_rd, mem_wr, if_ack, d_ack});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
            errors++; $display("FAIL reset_data addr %h wdata %h ird %h drd %h exp all 0",
                               mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        checks++;
        if (dut.state_q !== IDLE || dut.cnt_q !== '0) begin
            errors++; $display("FAIL reset_state state %0d cnt %0d exp 0 0", dut.state_q, dut.cnt_q);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        int rd_cycles = 0;
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        #1;
        checks++;
        if (mem_rd !== 1'b0) begin
            errors++; $display("FAIL fetch_pregrant rd got %b exp 0", mem_rd);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 2) begin mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF; end
            #1;
            if (mem_rd === 1'b1) rd_cycles++;
            checks++;
            if (mem_addr !== 32'h100 || mem_wr !== 1'b0) begin
                errors++; $display("FAIL fetch_addr cyc %0d addr %h wr %b exp 100 0", k, mem_addr, mem_wr);
            end
            checks++;
            if (if_ack !== 1'(k == 2) || d_ack !== 1'b0) begin
                errors++; $display("FAIL fetch_ack cyc %0d if_ack %b d_ack %b exp %b 0", k, if_ack, d_ack, k == 2);
            end
            checks++;
            if (if_rdata !== ((k == 2) ? 32'hDEADBEEF : 32'h0)) begin
                errors++; $display("FAIL fetch_rdata cyc %0d got %h", k, if_rdata);
            end
        end
        @(negedge clk);
        mem_ack = 1'b0; if_req = 1'b0;
        #1;
        checks++;
        if (rd_cycles != 3 || mem_rd !== 1'b0) begin
            errors++; $display("FAIL fetch_strobe_len got %0d rd_now %b exp 3 0", rd_cycles, mem_rd);
        end
    endtask

    task automatic test_store();
        logic [DW-1:0] r;
        r = $urandom;
        @(negedge clk);
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h2000; d_wdata = 32'h12345678;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 1) begin mem_ack = 1'b1; mem_rdata = r; end
            #1;
            checks++;
            if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin
                errors++; $display("FAIL store_strobes cyc %0d wr %b rd %b exp 1 0", k, mem_wr, mem_rd);
            end
            checks++;
            if (mem_addr !== 32'h2000 || mem_wdata !== 32'h12345678) begin
                errors++; $display("FAIL store_fields cyc %0d addr %h wdata %h", k, mem_addr, mem_wdata);
            end
            checks++;
            if (d_ack !== 1'(k == 1) || if_ack !== 1'b0) begin
                errors++; $display("FAIL store_ack cyc %0d d_ack %b if_ack %b", k, d_ack, if_ack);
            end
            checks++;
            if (d_rdata !== ((k == 1) ? r : '0) || if_rdata !== '0) begin
                errors++; $display("FAIL store_rdata cyc %0d d_rdata %h if_rdata %h", k, d_rdata, if_rdata);
            end
        end
        @(negedge clk);
        mem_ack = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        #1;
        checks++;
        if ({mem_rd, mem_wr} !== 2'b00) begin
            errors++; $display("FAIL store_release got %b exp 00", {mem_rd, mem_wr});
        end
    endtask

    task automatic test_starve();
        logic [9:0] exp_if;
        exp_if = 10'b10_0001_0000;
        do_reset();
        if_req = 1'b1; if_addr = 32'h400;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h800;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            mem_ack = 1'b1; mem_rdata = $urandom;
            #1;
            checks++;
            if (mem_addr !== (exp_if[i] ? 32'h400 : 32'h800) || mem_rd !== 1'b1) begin
                errors++; $display("FAIL starve_order grant %0d addr %h rd %b exp_if %b", i, mem_addr, mem_rd, exp_if[i]);
            end
            checks++;
            if (if_ack !== exp_if[i] || d_ack !== !exp_if[i]) begin
                errors++; $display("FAIL starve_ack grant %0d if_ack %b d_ack %b", i, if_ack, d_ack);
            end
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            checks++;
            if ({mem_rd, mem_wr} !== 2'b00) begin
                errors++; $display("FAIL starve_idle grant %0d got %b exp 00", i, {mem_rd, mem_wr});
            end
        end
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        do_reset();
        if_req = 1'b1; if_addr = 32'h40;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h30;
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE0001;
        #1;
        checks++;
        if (mem_addr !== 32'h30 || mem_rd !== 1'b1 || d_ack !== 1'b1 || d_rdata !== 32'hCAFE0001) begin
            errors++; $display("FAIL simul_data_first addr %h rd %b d_ack %b d_rdata %h", mem_addr, mem_rd, d_ack, d_rdata);
        end
        @(negedge clk);
        mem_ack = 1'b0; d_req = 1'b0;
        #1;
        checks++;
        if ({mem_rd, mem_wr} !== 2'b00) begin
            errors++; $display("FAIL simul_idle got %b exp 00", {mem_rd, mem_wr});
        end
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE0002;
        #1;
        checks++;
        if (mem_addr !== 32'h40 || mem_rd !== 1'b1 || if_ack !== 1'b1 || if_rdata !== 32'hCAFE0002) begin
            errors++; $display("FAIL simul_fetch_next addr %h rd %b if_ack %b if_rdata %h", mem_addr, mem_rd, if_ack, if_rdata);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        if_req = 1'b1; if_addr = 32'h60;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h50; d_wdata = 32'h5555AAAA;
        @(negedge clk);
        #1;
        checks++;
        if (mem_wr !== 1'b1 || mem_addr !== 32'h50) begin
            errors++; $display("FAIL rstmid_busy wr %b addr %h exp 1 50", mem_wr, mem_addr);
        end
        rst = 1'b1; if_req = 1'b0; d_req = 1'b0;
        #1;
        checks++;
        if ({mem_rd, mem_wr, d_ack, if_ack} !== 4'b0000 || dut.state_q !== IDLE || dut.cnt_q !== '0) begin
            errors++; $display("FAIL rstmid_async out %b state %0d cnt %0d", {mem_rd, mem_wr, d_ack, if_ack}, dut.state_q, dut.cnt_q);
        end
        @(negedge clk);
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        #1;
        checks++;
        if (d_ack !== 1'b0 || if_ack !== 1'b0 || d_rdata !== '0 || if_rdata !== '0) begin
            errors++; $display("FAIL rstmid_late_ack d_ack %b if_ack %b d_rdata %h", d_ack, if_ack, d_rdata);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({mem_rd, mem_wr} !== 2'b00 || dut.state_q !== IDLE || dut.cnt_q !== '0) begin
            errors++; $display("FAIL rstmid_after strobes %b state %0d cnt %0d", {mem_rd, mem_wr}, dut.state_q, dut.cnt_q);
        end
    endtask

    task automatic test_idle_ack();
        do_reset();
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = $urandom | 32'h1;
        #1;
        checks++;
        if (if_ack !== 1'b0 || d_ack !== 1'b0 || if_rdata !== '0 || d_rdata !== '0) begin
            errors++; $display("FAIL idle_ack acks %b%b rdata %h %h exp 0", if_ack, d_ack, if_rdata, d_rdata);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++;
        if ({mem_rd, mem_wr} !== 2'b00 || dut.state_q !== IDLE) begin
            errors++; $display("FAIL idle_ack_state strobes %b state %0d", {mem_rd, mem_wr}, dut.state_q);
        end
    endtask

    task automatic test_strict_priority();
        do_reset();
        if_req = 1'b1; if_addr = 32'h70;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h80;
        @(negedge clk);
        #1;
        checks++;
        if (mem_addr !== 32'h80 || mem_addr0 !== 32'h70 || mem_rd0 !== 1'b1) begin
            errors++; $display("FAIL strict_grant lim4 addr %h lim0 addr %h rd %b exp 80 70 1", mem_addr, mem_addr0, mem_rd0);
        end
        mem_ack = 1'b1; mem_rdata = 32'h77;
        #1;
        checks++;
        if (if_ack0 !== 1'b1 || d_ack0 !== 1'b0 || if_rdata0 !== 32'h77 || d_ack !== 1'b1) begin
            errors++; $display("FAIL strict_ack lim0 if %b d %b rd %h lim4 d %b", if_ack0, d_ack0, if_rdata0, d_ack);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    // Transaction-level model: who owns memory, what was latched, how long fetch waited.
    task automatic test_random();
        int            m_st = 0;
        int            m_cnt = 0;
        logic [AW-1:0] m_addr = '0;
        logic [DW-1:0] m_wdata = '0;
        logic          m_wr = 1'b0;
        logic          if_p = 1'b0, d_p = 1'b0, dwr = 1'b0;
        logic [AW-1:0] ia = '0, da = '0;
        logic [DW-1:0] dw = '0;
        logic          e_rd, e_wr, e_ia, e_da;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!if_p && $urandom_range(3) == 0) begin if_p = 1'b1; ia = $urandom; end
            if (!d_p && $urandom_range(2) == 0) begin
                d_p = 1'b1; da = $urandom; dw = $urandom; dwr = 1'($urandom_range(1));
            end
            if_req = if_p; if_addr = ia; d_req = d_p; d_addr = da; d_wdata = dw; d_wr = dwr;
            mem_ack = ($urandom_range(2) == 0); mem_rdata = $urandom;
            #1;
            e_rd = (m_st == 1) || (m_st == 2 && !m_wr);
            e_wr = (m_st == 2) && m_wr;
            e_ia = (m_st == 1) && mem_ack;
            e_da = (m_st == 2) && mem_ack;
            checks++;
            if (mem_rd !== e_rd || mem_wr !== e_wr) begin
                errors++; $display("FAIL rand_strobes cyc %0d rd %b wr %b exp %b %b", c, mem_rd, mem_wr, e_rd, e_wr);
            end
            checks++;
            if (m_st != 0 && (mem_addr !== m_addr || (m_st == 2 && mem_wdata !== m_wdata))) begin
                errors++; $display("FAIL rand_fields cyc %0d addr %h wdata %h exp %h %h", c, mem_addr, mem_wdata, m_addr, m_wdata);
            end
            checks++;
            if (if_ack !== e_ia || d_ack !== e_da) begin
                errors++; $display("FAIL rand_acks cyc %0d if %b d %b exp %b %b", c, if_ack, d_ack, e_ia, e_da);
            end
            checks++;
            if (if_rdata !== (e_ia ? mem_rdata : '0) || d_rdata !== (e_da ? mem_rdata : '0)) begin
                errors++; $display("FAIL rand_rdata cyc %0d if %h d %h mem %h", c, if_rdata, d_rdata, mem_rdata);
            end
            if (m_st != 0) begin
                if (mem_ack) begin
                    if (m_st == 1) if_p = 1'b0; else d_p = 1'b0;
                    m_st = 0;
                end
            end else if (d_p && !(if_p && m_cnt == LIM)) begin
                m_st = 2; m_addr = da; m_wdata = dw; m_wr = dwr;
                m_cnt = if_p ? ((m_cnt + 1 > LIM) ? LIM : m_cnt + 1) : 0;
            end else if (if_p) begin
                m_st = 1; m_addr = ia; m_cnt = 0;
            end else begin
                m_cnt = 0;
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_starve();
        test_simultaneous();
        test_reset_mid();
        test_idle_ack();
        test_strict_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
